// File: rtl/adc_pkg.sv
// Shared types and sizing helpers for the ADC sample controller.
package adc_pkg;

  localparam int unsigned RESULT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_ACCUM,
    ST_PRESENT
  } adc_ctrl_state_t;

  // Bits needed to hold a counter running 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_period_timer.sv
// Run-gated modulo-PERIOD counter; tick_c marks the last count of each period.
module adc_period_timer
  import adc_pkg::*;
#(
  parameter int unsigned PERIOD = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tick_c
);

  localparam int unsigned CW = cnt_width(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           count <= '0;
    else if (!run)          count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + CW'(1);
  end

  assign tick_c = run && (count == LAST);

endmodule

// File: rtl/adc_sample_ctrl.sv
// Periodic SAR conversion scheduler with box-car averaging and valid/ready output.
// Optional ADC_MIN_MAX_EN adds per-window min/max outputs.
module adc_sample_ctrl
  import adc_pkg::*;
#(
  parameter int unsigned WIDTH         = RESULT_W,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned SAMPLE_PERIOD = 500000,
  parameter int unsigned CONV_TIMEOUT  = 1200000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             conv_done,
  input  logic [WIDTH-1:0] conv_result,
  output logic             conv_enable,
  output logic [WIDTH-1:0] avg_data,
  output logic             avg_valid,
  input  logic             avg_ready,
  output logic             overrun,
  output logic             timeout,
  input  logic             clr_status
`ifdef ADC_MIN_MAX_EN
  ,
  output logic [WIDTH-1:0] win_min,
  output logic [WIDTH-1:0] win_max
`endif
);

  localparam int unsigned ACC_W = WIDTH + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int unsigned TMO_W = cnt_width(CONV_TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((32'd1 << AVG_LOG2) - 32'd1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CONV_TIMEOUT - 1);

  adc_ctrl_state_t  state, state_d;
  logic             tick_c;
  logic             conv_enable_d, avg_valid_d, overrun_d, timeout_d;
  logic [WIDTH-1:0] result, result_d, avg_data_d;
  logic [ACC_W-1:0] acc, acc_d, sum;
  logic [CNT_W-1:0] count, count_d;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
`ifdef ADC_MIN_MAX_EN
  logic [WIDTH-1:0] mn_run, mx_run, mn_run_d, mx_run_d, mn_new, mx_new;
  logic [WIDTH-1:0] win_min_d, win_max_d;
`endif

  adc_period_timer #(.PERIOD(SAMPLE_PERIOD)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .tick_c  (tick_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state;
    conv_enable_d = conv_enable;
    result_d      = result;
    acc_d         = acc;
    count_d       = count;
    tmo_cnt_d     = tmo_cnt;
    avg_data_d    = avg_data;
    avg_valid_d   = avg_valid;
    overrun_d     = overrun & ~clr_status;
    timeout_d     = timeout & ~clr_status;
    sum           = acc + ACC_W'(result);
`ifdef ADC_MIN_MAX_EN
    mn_run_d  = mn_run;
    mx_run_d  = mx_run;
    win_min_d = win_min;
    win_max_d = win_max;
    mn_new    = (count == '0 || result < mn_run) ? result : mn_run;
    mx_new    = (count == '0 || result > mx_run) ? result : mx_run;
`endif

    // Set beats clear; skipped slots are not queued.
    if (tick_c && state != ST_IDLE) overrun_d = 1'b1;

    case (state)
      ST_IDLE: begin
        if (tick_c) begin
          state_d       = ST_CONVERT;
          conv_enable_d = 1'b1;
          tmo_cnt_d     = '0;
        end
      end
      ST_CONVERT: begin
        if (conv_done) begin
          result_d      = conv_result;
          conv_enable_d = 1'b0;
          state_d       = ST_ACCUM;
        end else if (tmo_cnt == TMO_LAST) begin
          timeout_d     = 1'b1;
          conv_enable_d = 1'b0;
          acc_d         = '0;
          count_d       = '0;
          state_d       = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt + TMO_W'(1);
        end
      end
      ST_ACCUM: begin
        if (count == LAST_CNT) begin
          avg_data_d  = WIDTH'(sum >> AVG_LOG2);
          avg_valid_d = 1'b1;
          acc_d       = '0;
          count_d     = '0;
          state_d     = ST_PRESENT;
`ifdef ADC_MIN_MAX_EN
          win_min_d = mn_new;
          win_max_d = mx_new;
`endif
        end else begin
          acc_d   = sum;
          count_d = count + CNT_W'(1);
          state_d = ST_IDLE;
`ifdef ADC_MIN_MAX_EN
          mn_run_d = mn_new;
          mx_run_d = mx_new;
`endif
        end
      end
      ST_PRESENT: begin
        if (avg_ready) begin
          avg_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      conv_enable <= 1'b0;
      result      <= '0;
      acc         <= '0;
      count       <= '0;
      tmo_cnt     <= '0;
      avg_data    <= '0;
      avg_valid   <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
`ifdef ADC_MIN_MAX_EN
      mn_run  <= '0;
      mx_run  <= '0;
      win_min <= '0;
      win_max <= '0;
`endif
    end else begin
      state       <= state_d;
      conv_enable <= conv_enable_d;
      result      <= result_d;
      acc         <= acc_d;
      count       <= count_d;
      tmo_cnt     <= tmo_cnt_d;
      avg_data    <= avg_data_d;
      avg_valid   <= avg_valid_d;
      overrun     <= overrun_d;
      timeout     <= timeout_d;
`ifdef ADC_MIN_MAX_EN
      mn_run  <= mn_run_d;
      mx_run  <= mx_run_d;
      win_min <= win_min_d;
      win_max <= win_max_d;
`endif
    end
  end

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench for adc_sample_ctrl (averaging DUT plus a pass-through instance).
module tb_adc_sample_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run, conv_done, avg_ready, clr_status;
  logic [7:0] conv_result;
  logic       conv_enable, avg_valid, overrun, timeout;
  logic [7:0] avg_data;
`ifdef ADC_MIN_MAX_EN
  logic [7:0] win_min, win_max, win_min0, win_max0;
`endif

  logic       run0, done0, ready0, clr0;
  logic [7:0] res0;
  logic       en0, valid0, ovr0, tmo0;
  logic [7:0] data0;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned ref_cyc = 0;

  typedef struct packed {
    logic [3:0][7:0] s;
    logic [7:0]      avg;
    logic [7:0]      mn;
    logic [7:0]      mx;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_sample_ctrl #(.WIDTH(8), .AVG_LOG2(2), .SAMPLE_PERIOD(20), .CONV_TIMEOUT(50)) dut (
    .clk (clk), .reset_n (reset_n), .run (run), .conv_done (conv_done),
    .conv_result (conv_result), .conv_enable (conv_enable), .avg_data (avg_data),
    .avg_valid (avg_valid), .avg_ready (avg_ready), .overrun (overrun),
    .timeout (timeout), .clr_status (clr_status)
`ifdef ADC_MIN_MAX_EN
    , .win_min (win_min), .win_max (win_max)
`endif
  );

  adc_sample_ctrl #(.WIDTH(8), .AVG_LOG2(0), .SAMPLE_PERIOD(20), .CONV_TIMEOUT(50)) dut0 (
    .clk (clk), .reset_n (reset_n), .run (run0), .conv_done (done0),
    .conv_result (res0), .conv_enable (en0), .avg_data (data0),
    .avg_valid (valid0), .avg_ready (ready0), .overrun (ovr0),
    .timeout (tmo0), .clr_status (clr0)
`ifdef ADC_MIN_MAX_EN
    , .win_min (win_min0), .win_max (win_max0)
`endif
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Wait (bounded) for conv_enable; optionally check slot spacing from ref_cyc.
  task automatic wait_rise(input string name, input bit chk_int);
    int n = 0;
    while (!conv_enable && n < 400) begin
      step();
      n++;
    end
    if (!conv_enable) check({name, "_rise_wait"}, 32'(conv_enable), 1);
    else if (chk_int) check({name, "_rise_spacing"}, cyc - ref_cyc, 20);
    ref_cyc = cyc;
  endtask

  // SAR model: answer two cycles after enable, then enable must fall.
  task automatic sar_reply(input string name, input logic [7:0] v);
    step();
    step();
    conv_done   = 1'b1;
    conv_result = v;
    step();
    conv_done   = 1'b0;
    conv_result = 8'd0;
    check({name, "_enable_drop"}, 32'(conv_enable), 0);
  endtask

  task automatic sample(input string name, input logic [7:0] v, input bit last,
                        input logic [7:0] exp_avg, input bit chk_int);
    wait_rise(name, chk_int);
    sar_reply(name, v);
    check({name, "_accum_cycle"}, 32'(avg_valid), 0);
    step();
    check({name, "_valid"}, 32'(avg_valid), 32'(last));
    if (last) begin
      check({name, "_data"}, 32'(avg_data), 32'(exp_avg));
      if (avg_ready) begin
        step();
        check({name, "_accept"}, 32'(avg_valid), 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p0v[2];
    bit stable, saw_en;
    int n;

    vecs[0] = '{s: {8'd41, 8'd30, 8'd20, 8'd10},     avg: 8'd25,  mn: 8'd10,  mx: 8'd41};
    vecs[1] = '{s: {8'd0, 8'd0, 8'd0, 8'd0},         avg: 8'd0,   mn: 8'd0,   mx: 8'd0};
    vecs[2] = '{s: {8'd255, 8'd255, 8'd255, 8'd255}, avg: 8'd255, mn: 8'd255, mx: 8'd255};
    vecs[3] = '{s: {8'd5, 8'd3, 8'd2, 8'd1},         avg: 8'd2,   mn: 8'd1,   mx: 8'd5};
    vecs[4] = '{s: {8'd254, 8'd255, 8'd255, 8'd255}, avg: 8'd254, mn: 8'd254, mx: 8'd255};
    p0v[0] = 8'hFF;
    p0v[1] = 8'h5A;

    reset_n = 1'b0; run = 1'b0; conv_done = 1'b0; conv_result = 8'd0;
    avg_ready = 1'b1; clr_status = 1'b0;
    run0 = 1'b0; done0 = 1'b0; res0 = 8'd0; ready0 = 1'b1; clr0 = 1'b0;

    step();
    check("rst_enable", 32'(conv_enable), 0);
    check("rst_valid", 32'(avg_valid), 0);
    check("rst_data", 32'(avg_data), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_timeout", 32'(timeout), 0);
    step();
    reset_n = 1'b1;

    // Pass-through instance: average equals the raw result two cycles later.
    run0 = 1'b1;
    foreach (p0v[k]) begin
      n = 0;
      while (!en0 && n < 100) begin step(); n++; end
      check("p0_enable", 32'(en0), 1);
      done0 = 1'b1; res0 = p0v[k];
      step();
      done0 = 1'b0; res0 = 8'd0;
      check("p0_accum_cycle", 32'(valid0), 0);
      step();
      check("p0_valid", 32'(valid0), 1);
      check("p0_data", 32'(data0), 32'(p0v[k]));
`ifdef ADC_MIN_MAX_EN
      check("p0_min", 32'(win_min0), 32'(p0v[k]));
      check("p0_max", 32'(win_max0), 32'(p0v[k]));
`endif
      step();
      check("p0_accept", 32'(valid0), 0);
    end
    run0 = 1'b0;
    check("p0_overrun", 32'(ovr0), 0);
    check("p0_timeout", 32'(tmo0), 0);

    // Averaging vectors on a continuously running sample clock.
    run = 1'b1;
    ref_cyc = cyc;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++)
        sample($sformatf("vec%0d_s%0d", i, j), vecs[i].s[j], j == 3, vecs[i].avg, 1'b1);
`ifdef ADC_MIN_MAX_EN
      check($sformatf("vec%0d_min", i), 32'(win_min), 32'(vecs[i].mn));
      check($sformatf("vec%0d_max", i), 32'(win_max), 32'(vecs[i].mx));
`endif
    end
    check("vec_overrun", 32'(overrun), 0);

    // Backpressure: average held across three periods, skipped slots flagged.
    avg_ready = 1'b0;
    for (int j = 0; j < 4; j++) sample("bp", 8'(40 + j), j == 3, 8'd41, 1'b0);
    stable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!avg_valid || avg_data != 8'd41 || conv_enable) stable = 1'b0;
    end
    check("bp_hold_stable", 32'(stable), 1);
    check("bp_overrun", 32'(overrun), 1);
    run = 1'b0;
    avg_ready = 1'b1;
    step();
    check("bp_accept", 32'(avg_valid), 0);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    check("bp_clear", 32'(overrun), 0);

    // Timeout discards a two-sample partial sum.
    run = 1'b1;
    ref_cyc = cyc;
    sample("tmo_pre0", 8'd200, 1'b0, 8'd0, 1'b1);
    sample("tmo_pre1", 8'd200, 1'b0, 8'd0, 1'b1);
    wait_rise("tmo", 1'b1);
    n = 0;
    while (conv_enable && n < 200) begin step(); n++; end
    check("tmo_enable_len", n, 50);
    check("tmo_flag", 32'(timeout), 1);
    check("tmo_overrun", 32'(overrun), 1);
    for (int j = 0; j < 4; j++) sample("tmo_post", 8'd100, j == 3, 8'd100, 1'b0);

    // Reset in the middle of a conversion.
    wait_rise("rst_mid", 1'b0);
    step();
    step();
    check("rst_mid_pre_enable", 32'(conv_enable), 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_enable", 32'(conv_enable), 0);
    check("rst_mid_data", 32'(avg_data), 0);
    check("rst_mid_valid", 32'(avg_valid), 0);
    check("rst_mid_overrun", 32'(overrun), 0);
    check("rst_mid_timeout", 32'(timeout), 0);
    repeat (3) step();
    reset_n = 1'b1;
    ref_cyc = cyc;
    sample("post_rst0", 8'd7, 1'b0, 8'd0, 1'b1);
    sample("post_rst1", 8'd8, 1'b0, 8'd0, 1'b1);
    sample("post_rst2", 8'd9, 1'b0, 8'd0, 1'b1);
    sample("post_rst3", 8'd10, 1'b1, 8'd8, 1'b1);

    // run dropped right after a tick: in-flight sample kept, no new requests.
    wait_rise("rundrop", 1'b1);
    run = 1'b0;
    sar_reply("rundrop", 8'd4);
    saw_en = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (conv_enable) saw_en = 1'b1;
      conv_done   = (i == 10);
      conv_result = (i == 10) ? 8'd255 : 8'd0;
    end
    conv_done = 1'b0;
    check("rundrop_no_enable", 32'(saw_en), 0);
    check("rundrop_no_valid", 32'(avg_valid), 0);
    run = 1'b1;
    ref_cyc = cyc;
    sample("rundrop1", 8'd8, 1'b0, 8'd0, 1'b1);
    sample("rundrop2", 8'd12, 1'b0, 8'd0, 1'b1);
    sample("rundrop3", 8'd16, 1'b1, 8'd10, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_ctrl.md
Name: adc_sample_ctrl

Overview:
Sample-rate scheduler and result conditioner that sits directly downstream of the SAR conversion FSM. It raises that FSM's enable on a fixed sample period and captures each 8-bit conversion result. It box-car averages 2^AVG_LOG2 results and presents the average to the display/UART path over a valid/ready handshake. Missed sample slots and conversion timeouts are flagged as sticky status bits.

Parameters:
WIDTH, 8, conversion result width in bits.
AVG_LOG2, 2, log2 of the number of samples per average (0..4; 0 = pass-through).
SAMPLE_PERIOD, 500000, clk cycles between sample-slot ticks (>= 2).
CONV_TIMEOUT, 1200000, maximum clk cycles to wait for conv_done before aborting.

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous active-low reset.
run  input  1  level; 1 = periodic sampling active.
conv_done  input  1  single-cycle pulse from SAR FSM; conv_result is valid in the same cycle.
conv_result  input  WIDTH  conversion result, sampled only when conv_done=1.
conv_enable  output  1  enable to SAR FSM, high while a conversion is requested.
avg_data  output  WIDTH  averaged result.
avg_valid  output  1  avg_data valid; held until accepted.
avg_ready  input  1  consumer accept.
overrun  output  1  sticky: a sample tick arrived while not in IDLE.
timeout  output  1  sticky: a conversion exceeded CONV_TIMEOUT.
clr_status  input  1  synchronous clear of overrun/timeout.

Behaviour:
- Reset values: conv_enable=0, avg_data=0, avg_valid=0, overrun=0, timeout=0. Accumulator, sample count and period timer are 0. State is IDLE.
- Period timer: free-runs while run=1, counting 0..SAMPLE_PERIOD-1. Tick is asserted when the count equals SAMPLE_PERIOD-1, then the count wraps to 0. When run=0 the timer is held at 0.
- States: IDLE, CONVERT, ACCUM, PRESENT.
- IDLE: on tick, go to CONVERT and set conv_enable=1 from the next cycle.
- CONVERT: conv_enable=1 and the timeout counter increments each cycle.
  - On conv_done: latch conv_result, drop conv_enable the next cycle, go to ACCUM.
  - If the counter reaches CONV_TIMEOUT-1 without conv_done: set timeout, drop conv_enable, discard the partial accumulation (acc=0, count=0), return to IDLE.
- ACCUM (1 cycle): acc += result; count += 1.
  - If count was 2^AVG_LOG2-1: avg_data <= (acc+result) >> AVG_LOG2 (truncating), avg_valid <= 1, clear acc and count, go to PRESENT.
  - Otherwise go to IDLE.
  - acc width is WIDTH+AVG_LOG2, so the accumulator never wraps.
- PRESENT: hold avg_data and avg_valid stable until avg_valid & avg_ready. On that cycle avg_valid drops next cycle and the state returns to IDLE. Ticks are not queued.
- Latency: the average appears 2 cycles after the last conv_done (ACCUM, then registered output).
- Overrun: a tick in any state other than IDLE sets overrun, and that slot is skipped. If clr_status and a set event occur in the same cycle, the set wins.
- run deasserted mid-operation: the current conversion and PRESENT complete normally. No new ticks are issued. The partial accumulation is retained.
- conv_done outside CONVERT is ignored.
- reset_n asserted at any time returns everything to reset values immediately, including dropping conv_enable.

Optional Feature:
ADC_MIN_MAX_EN: when defined, adds outputs win_min and win_max (WIDTH each, reset 0). They hold the minimum and maximum raw results of the window just averaged and update together with avg_data. When undefined, these ports and their logic do not exist.

Decomposition:
- Package adc_pkg holds:
  - the state enum adc_ctrl_state_t;
  - localparam RESULT_W=8;
  - a helper function clog2-based width for the period/timeout counters.
- One natural sub-module: adc_period_timer (run-gated modulo counter with tick output), reusable by other sampled blocks.

Test Plan:
- SAMPLE_PERIOD=20, AVG_LOG2=2, SAR model returns 10,20,30,41 with avg_ready=1 -> single avg_valid pulse with avg_data=25; conv_enable pulses exactly 4 times, each starting 1 cycle after a tick.
- AVG_LOG2=0, result 0xFF -> avg_data=0xFF 2 cycles after conv_done.
- avg_ready held 0 for 3 periods -> avg_data stable and avg_valid=1 throughout; overrun=1. After avg_ready=1 for one cycle, avg_valid=0. clr_status -> overrun=0.
- SAR model never returns conv_done, CONV_TIMEOUT=50 -> conv_enable drops after 50 cycles, timeout=1. The next 4 good samples of 100 give avg_data=100 (no stale partial sum).
- reset_n pulled low in the middle of CONVERT -> conv_enable=0 and all outputs at reset values in the same cycle; a normal average follows after release.
- run dropped immediately after a tick -> the in-flight conversion completes and is accumulated, then no further conv_enable while run=0.
